// File: rtl/fsmc_pkg.sv
// Shared FSMC master definitions: FSM state encoding, default phase timings,
// well-known bus addresses and the timing-parameter range check.
package fsmc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        AHOLD = 3'd2,
        TURN  = 3'd3,
        DATA  = 3'd4,
        DHOLD = 3'd5,
        GAP   = 3'd6
    } fsmc_state_t;

    localparam int T_ADDSET_DEF = 5;
    localparam int T_ADDHLD_DEF = 1;
    localparam int T_TURN_DEF   = 2;
    localparam int T_DATAST_DEF = 10;
    localparam int T_DHLD_DEF   = 3;
    localparam int T_GAP_DEF    = 8;

    localparam logic [17:0] READ_STATE_ADDR = 18'h04000;
    localparam logic [17:0] INFO_BASE       = 18'h10000;

    // Every phase length must fit the 8-bit phase counter and be non-empty.
    function automatic bit t_ok(input int t);
        return (t >= 1) && (t <= 255);
    endfunction

endpackage

// File: rtl/fsmc_phase_cnt.sv
// Phase timer: 8-bit down-counter loaded with (phase length - 1);
// done is high on the last cycle of the phase.
module fsmc_phase_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 8'd0;
        else if (load)
            cnt <= load_val;
        else if (cnt != 8'd0)
            cnt <= cnt - 8'd1;
    end

    assign done = (cnt == 8'd0);

endmodule

// File: rtl/fsmc_master.sv
// FSMC-style multiplexed AD bus master: one request at a time, fixed phase timing.
// Optional FSMC_MASTER_RDSYNC_EN: 2-flop ad_in synchronizer, read DATA phase +2 cycles.
module fsmc_master
    import fsmc_pkg::*;
#(
    parameter int T_ADDSET = T_ADDSET_DEF,
    parameter int T_ADDHLD = T_ADDHLD_DEF,
    parameter int T_TURN   = T_TURN_DEF,
    parameter int T_DATAST = T_DATAST_DEF,
    parameter int T_DHLD   = T_DHLD_DEF,
    parameter int T_GAP    = T_GAP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [17:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [17:0] ad_out,
    output logic        ad_oe,
    input  logic [17:0] ad_in,
    output logic        nadv,
    output logic        nwe,
    output logic        noe,
    output logic        busy
);

`ifdef FSMC_MASTER_RDSYNC_EN
    localparam int RD_EXTRA = 2;
    logic [15:0] ad_sync1, ad_sync2;
    always_ff @(posedge clk) begin
        if (rst) begin
            ad_sync1 <= 16'd0;
            ad_sync2 <= 16'd0;
        end else begin
            ad_sync1 <= ad_in[15:0];
            ad_sync2 <= ad_sync1;
        end
    end
    logic [15:0] ad_s;
    assign ad_s = ad_sync2;
`else
    localparam int RD_EXTRA = 0;
    logic [15:0] ad_s;
    assign ad_s = ad_in[15:0];
`endif

    // Upper AD bits only carry address; read data is 16 bits wide.
    logic unused_ad_hi;
    assign unused_ad_hi = ^ad_in[17:16];

    if (!t_ok(T_ADDSET) || !t_ok(T_ADDHLD) || !t_ok(T_TURN) ||
        !t_ok(T_DATAST) || !t_ok(T_DHLD) || !t_ok(T_GAP)) begin : g_bad_timing
        $error("fsmc_master: every T_* parameter must be in 1..255");
    end
    if (!t_ok(T_DATAST + RD_EXTRA)) begin : g_bad_datast
        $error("fsmc_master: T_DATAST too large for synchronized read phase");
    end

    fsmc_state_t state, nxt;
    logic        wr_q;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic        done, load;
    logic [7:0]  load_val;

    fsmc_phase_cnt u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    // In IDLE the request fields are not latched yet, so look at them directly.
    logic        cur_wr;
    logic [17:0] cur_addr;
    logic [15:0] cur_wdata;
    assign cur_wr    = (state == IDLE) ? req_wr    : wr_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (req_valid && req_ready) nxt = ADDR;
            ADDR:    if (done) nxt = AHOLD;
            AHOLD:   if (done) nxt = TURN;
            TURN:    if (done) nxt = DATA;
            DATA:    if (done) nxt = wr_q ? DHOLD : GAP;
            DHOLD:   if (done) nxt = GAP;
            GAP:     if (done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The counter reloads with the incoming phase length on every state change.
    always_comb begin
        load     = (nxt != state);
        load_val = 8'd0;
        unique case (nxt)
            ADDR:    load_val = 8'(T_ADDSET - 1);
            AHOLD:   load_val = 8'(T_ADDHLD - 1);
            TURN:    load_val = 8'(T_TURN - 1);
            DATA:    load_val = wr_q ? 8'(T_DATAST - 1) : 8'(T_DATAST + RD_EXTRA - 1);
            DHOLD:   load_val = 8'(T_DHLD - 1);
            GAP:     load_val = 8'(T_GAP - 1);
            default: load_val = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= 18'd0;
            wdata_q   <= 16'd0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            nadv      <= 1'b1;
            nwe       <= 1'b1;
            noe       <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out    <= 18'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'd0;
        end else begin
            state <= nxt;
            if (state == IDLE && nxt == ADDR) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // Outputs are registered from the next state so they line up with it.
            req_ready <= (nxt == IDLE);
            busy      <= (nxt != IDLE);
            nadv      <= (nxt != ADDR);
            nwe       <= !(cur_wr && (nxt == AHOLD || nxt == TURN || nxt == DATA));
            noe       <= !(!cur_wr && nxt == DATA);
            unique case (nxt)
                ADDR, AHOLD: begin
                    ad_oe  <= 1'b1;
                    ad_out <= cur_addr;
                end
                DATA, DHOLD: begin
                    ad_oe  <= cur_wr;
                    ad_out <= cur_wr ? {2'b00, cur_wdata} : 18'd0;
                end
                default: begin
                    ad_oe  <= 1'b0;
                    ad_out <= 18'd0;
                end
            endcase
            rsp_valid <= (state == DATA) && (nxt == GAP) && !wr_q;
            if (state == DATA && nxt == GAP && !wr_q)
                rsp_rdata <= ad_s;
        end
    end

endmodule

// File: tb/tb_fsmc_master.sv
// Directed bench for fsmc_master: default-timing instance plus an all-ones timing instance.
module tb_fsmc_master;
    import fsmc_pkg::*;

`ifdef FSMC_MASTER_RDSYNC_EN
    localparam int RD_EXTRA = 2;
`else
    localparam int RD_EXTRA = 0;
`endif
    localparam int WR_LAT = 5 + 1 + 2 + 10 + 3 + 8;   // 29
    localparam int RD_LAT = 5 + 1 + 2 + 10 + 8 + RD_EXTRA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default-timing DUT
    logic        req_valid = 1'b0, req_wr = 1'b0;
    logic [17:0] req_addr = 18'd0;
    logic [15:0] req_wdata = 16'd0;
    logic        req_ready, rsp_valid, ad_oe, nadv, nwe, noe, busy;
    logic [15:0] rsp_rdata;
    logic [17:0] ad_out, ad_in;
    logic [15:0] rd_val = 16'd0;
    assign ad_in = noe ? 18'd0 : {2'b00, rd_val};

    fsmc_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ad_out(ad_out), .ad_oe(ad_oe),
        .ad_in(ad_in), .nadv(nadv), .nwe(nwe), .noe(noe), .busy(busy)
    );

    // all-T=1 DUT
    logic        req_valid_f = 1'b0, req_wr_f = 1'b0;
    logic [17:0] req_addr_f = 18'd0;
    logic [15:0] req_wdata_f = 16'd0;
    logic        req_ready_f, rsp_valid_f, ad_oe_f, nadv_f, nwe_f, noe_f, busy_f;
    logic [15:0] rsp_rdata_f;
    logic [17:0] ad_out_f, ad_in_f;
    logic [15:0] rd_val_f = 16'd0;
    assign ad_in_f = noe_f ? 18'd0 : {2'b00, rd_val_f};

    fsmc_master #(.T_ADDSET(1), .T_ADDHLD(1), .T_TURN(1), .T_DATAST(1), .T_DHLD(1), .T_GAP(1)) dut_f (
        .clk(clk), .rst(rst), .req_valid(req_valid_f), .req_ready(req_ready_f),
        .req_wr(req_wr_f), .req_addr(req_addr_f), .req_wdata(req_wdata_f),
        .rsp_valid(rsp_valid_f), .rsp_rdata(rsp_rdata_f), .ad_out(ad_out_f), .ad_oe(ad_oe_f),
        .ad_in(ad_in_f), .nadv(nadv_f), .nwe(nwe_f), .noe(noe_f), .busy(busy_f)
    );

    int nvec = 0;
    int nmis = 0;
    int viol = 0;
    int rsp_cnt = 0;

    // bus-protocol monitor: strobe overlap and read-drive contention
    always @(negedge clk) begin
        if ((!nadv && (!nwe || !noe)) || (!noe && ad_oe)) viol++;
        if ((!nadv_f && (!nwe_f || !noe_f)) || (!noe_f && ad_oe_f)) viol++;
        if (rsp_valid) rsp_cnt++;
    end

    // Called at a negedge; returns one negedge after the accepting posedge.
    task automatic issue(input logic wr, input logic [17:0] a, input logic [15:0] d, output bit ok);
        req_wr = wr; req_addr = a; req_wdata = d; req_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic issue_f(input logic wr, input logic [17:0] a, input logic [15:0] d, output bit ok);
        req_wr_f = wr; req_addr_f = a; req_wdata_f = d; req_valid_f = 1'b1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready_f) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        req_valid_f = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if ({nadv, nwe, noe, ad_oe, busy, req_ready, rsp_valid} !== 7'b1110000 ||
            ad_out !== 18'd0 || rsp_rdata !== 16'd0) begin
            nmis++;
            $display("FAIL reset_state: got nadv/nwe/noe/oe/busy/rdy/rv=%b ad_out=%h rdata=%h, want 1110000 0 0",
                     {nadv, nwe, noe, ad_oe, busy, req_ready, rsp_valid}, ad_out, rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (req_ready !== 1'b1 || req_ready_f !== 1'b1) begin
            nmis++;
            $display("FAIL ready_after_reset: got %b/%b want 1/1", req_ready, req_ready_f);
        end
    endtask

    task automatic test_write();
        bit ok;
        int n_adv = 0, n_we = 0, n_busy = 0, n_data = 0, n_addr = 0;
        issue(1'b1, READ_STATE_ADDR, 16'h0001, ok);
        nvec++;
        if (!ok) begin nmis++; $display("FAIL write_accept: got timeout want accept"); end
        for (int i = 0; i < 45; i++) begin
            if (!nadv) n_adv++;
            if (!nwe) n_we++;
            if (busy) n_busy++;
            if (ad_oe && ad_out == 18'h00001) n_data++;
            if (ad_oe && ad_out == READ_STATE_ADDR) n_addr++;
            @(negedge clk);
        end
        nvec++; if (n_adv != 5)   begin nmis++; $display("FAIL write_nadv_low: got %0d want 5", n_adv); end
        nvec++; if (n_we != 13)   begin nmis++; $display("FAIL write_nwe_low: got %0d want 13", n_we); end
        nvec++; if (n_data != 13) begin nmis++; $display("FAIL write_data_cycles: got %0d want 13", n_data); end
        nvec++; if (n_addr != 6)  begin nmis++; $display("FAIL write_addr_cycles: got %0d want 6", n_addr); end
        nvec++; if (n_busy != WR_LAT) begin nmis++; $display("FAIL write_busy: got %0d want %0d", n_busy, WR_LAT); end
    endtask

    task automatic test_read();
        bit ok;
        int n_oe = 0, n_busy = 0, n_rv = 0, n_addr = 0;
        logic [15:0] got = 16'd0;
        rd_val = 16'h07D5;
        issue(1'b0, 18'h00005, 16'hFFFF, ok);
        nvec++;
        if (!ok) begin nmis++; $display("FAIL read_accept: got timeout want accept"); end
        for (int i = 0; i < 45; i++) begin
            if (!noe) n_oe++;
            if (busy) n_busy++;
            if (ad_oe && ad_out == 18'h00005) n_addr++;
            if (rsp_valid) begin n_rv++; got = rsp_rdata; end
            @(negedge clk);
        end
        nvec++; if (n_oe != 10 + RD_EXTRA) begin nmis++; $display("FAIL read_noe_low: got %0d want %0d", n_oe, 10 + RD_EXTRA); end
        nvec++; if (n_rv != 1) begin nmis++; $display("FAIL read_rsp_pulses: got %0d want 1", n_rv); end
        nvec++; if (got !== 16'h07D5) begin nmis++; $display("FAIL read_rdata: got %h want 07d5", got); end
        nvec++; if (n_addr != 6) begin nmis++; $display("FAIL read_addr_cycles: got %0d want 6", n_addr); end
        nvec++; if (n_busy != RD_LAT) begin nmis++; $display("FAIL read_busy: got %0d want %0d", n_busy, RD_LAT); end
    endtask

    task automatic test_back_to_back();
        int acc = 0, last = 0, bad_gap = 0, n_rv = 0, bad_data = 0;
        bit drop = 1'b0;
        int budget = 1024 * (RD_LAT + 1) + 300;
        rd_val = 16'hA5C3;
        req_wr = 1'b0; req_addr = 18'h00100; req_valid = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (drop) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                if (acc > 0 && (c - last) != RD_LAT + 1) bad_gap++;
                last = c;
                acc++;
                if (acc == 1024) drop = 1'b1;
            end
            if (rsp_valid) begin
                n_rv++;
                if (rsp_rdata !== 16'hA5C3) bad_data++;
            end
            if (n_rv == 1024 && drop) break;
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (30) @(negedge clk);
        nvec++; if (acc != 1024) begin nmis++; $display("FAIL b2b_accepts: got %0d want 1024", acc); end
        nvec++; if (bad_gap != 0) begin nmis++; $display("FAIL b2b_accept_spacing: got %0d bad gaps want 0", bad_gap); end
        nvec++; if (n_rv != 1024) begin nmis++; $display("FAIL b2b_rsp_pulses: got %0d want 1024", n_rv); end
        nvec++; if (bad_data != 0) begin nmis++; $display("FAIL b2b_rdata: got %0d bad words want 0", bad_data); end
        nvec++; if (viol != 0) begin nmis++; $display("FAIL strobe_overlap: got %0d violations want 0", viol); end
    endtask

    task automatic test_reset_midwrite();
        bit ok;
        int rv0, n_rv = 0;
        logic [15:0] got = 16'd0;
        issue(1'b1, 18'h00123, 16'hBEEF, ok);
        nvec++;
        if (!ok) begin nmis++; $display("FAIL rstmid_accept: got timeout want accept"); end
        repeat (6) @(negedge clk);
        rv0 = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if ({nadv, nwe, noe, ad_oe, busy, req_ready} !== 6'b111000) begin
            nmis++;
            $display("FAIL rstmid_outputs: got nadv/nwe/noe/oe/busy/rdy=%b want 111000",
                     {nadv, nwe, noe, ad_oe, busy, req_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++; if (req_ready !== 1'b1) begin nmis++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        repeat (40) @(negedge clk);
        nvec++; if (rsp_cnt != rv0) begin nmis++; $display("FAIL rstmid_no_rsp: got %0d pulses want 0", rsp_cnt - rv0); end
        rd_val = 16'h3C5A;
        issue(1'b0, INFO_BASE, 16'h0, ok);
        nvec++;
        if (!ok) begin nmis++; $display("FAIL rstmid_new_accept: got timeout want accept"); end
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin n_rv++; got = rsp_rdata; end
            @(negedge clk);
        end
        nvec++;
        if (n_rv != 1 || got !== 16'h3C5A) begin
            nmis++; $display("FAIL rstmid_new_read: got %0d pulses data %h want 1 pulse data 3c5a", n_rv, got);
        end
    endtask

    task automatic test_min_timing();
        bit ok;
        int n_pre = 0, n_busy = 0, n_rv = 0;
        bit seen = 1'b0;
        logic [15:0] got = 16'd0;
        rd_val_f = 16'h1234;
        issue_f(1'b0, INFO_BASE + 18'h3, 16'h0, ok);
        nvec++;
        if (!ok) begin nmis++; $display("FAIL min_accept: got timeout want accept"); end
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_f) begin seen = 1'b1; n_rv++; got = rsp_rdata_f; end
            if (!seen && busy_f) n_pre++;
            if (busy_f) n_busy++;
            @(negedge clk);
        end
        nvec++; if (n_pre != 4 + RD_EXTRA) begin nmis++; $display("FAIL min_read_cycles: got %0d want %0d", n_pre, 4 + RD_EXTRA); end
        nvec++; if (n_rv != 1 || got !== 16'h1234) begin nmis++; $display("FAIL min_rdata: got %0d pulses %h want 1 pulse 1234", n_rv, got); end
        nvec++; if (n_busy != 5 + RD_EXTRA) begin nmis++; $display("FAIL min_busy: got %0d want %0d", n_busy, 5 + RD_EXTRA); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_min_timing();
        test_back_to_back();
        test_reset_midwrite();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/fsmc_master.md
FSMC_MASTER -- requirements
Module: fsmc_master

Interface
REQ-001 SHALL have parameter T_ADDSET, default 5: address-phase length in clk cycles (NADV low).
REQ-002 SHALL have parameter T_ADDHLD, default 1: address hold after NADV rises.
REQ-003 SHALL have parameter T_TURN, default 2: bus-release cycles before the data phase.
REQ-004 SHALL have parameter T_DATAST, default 10: data-phase length (NWE/NOE low).
REQ-005 SHALL have parameter T_DHLD, default 3: write data hold after NWE rises.
REQ-006 SHALL have parameter T_GAP, default 8: idle cycles after each transaction.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have ports req_valid/req_ready, input/output, 1/1: request handshake.
REQ-010 SHALL have ports req_wr, req_addr, req_wdata, all inputs, widths 1/18/16: 1 = write, bus address, write data.
REQ-011 SHALL have ports rsp_valid/rsp_rdata, outputs, 1/16: read-completion pulse and read data.
REQ-012 SHALL have ports ad_out/ad_oe/ad_in, output/output/input, 18/1/18: multiplexed AD bus; pad tristated when ad_oe=0.
REQ-013 SHALL have ports nadv, nwe, noe, outputs, 1 each: active-low bus strobes.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL register every output, with no combinational path from inputs to outputs.
REQ-016 SHALL assert req_ready only in IDLE, and SHALL accept a request on the edge where req_valid and req_ready are both high, latching req_wr, req_addr and req_wdata.
REQ-017 SHALL use FSM states IDLE, ADDR, AHOLD, TURN, DATA, DHOLD, GAP; each non-IDLE state SHALL last exactly its T_* cycles.
REQ-018 SHALL, in ADDR, drive nadv=0, ad_oe=1 and ad_out=latched address.
REQ-019 SHALL, in AHOLD, drive nadv=1 with the address still driven; for writes nwe=0 from the first AHOLD cycle.
REQ-020 SHALL, in TURN, drive ad_oe=0; for writes nwe stays 0.
REQ-021 SHALL, in DATA on a write, drive ad_oe=1 with ad_out={2'b00,wdata} and nwe=0; on a read, drive ad_oe=0 and noe=0.
REQ-022 SHALL, in DHOLD (writes only), drive nwe=1 with data still driven; reads SHALL go DATA->GAP directly.
REQ-023 SHALL, in GAP, deassert all strobes with ad_oe=0, then return to IDLE.
REQ-024 SHALL, on a read, capture ad_in[15:0] into rsp_rdata on the last DATA cycle and pulse rsp_valid for exactly one cycle, the first GAP cycle.
REQ-025 SHALL never let nadv=0 coincide with nwe=0 or noe=0, and SHALL never let noe=0 coincide with ad_oe=1.
REQ-026 SHALL ignore req_valid asserted during any non-IDLE state; such a request SHALL be held until IDLE.
REQ-027 SHALL give write latency (accept to IDLE) = T_ADDSET+T_ADDHLD+T_TURN+T_DATAST+T_DHLD+T_GAP, and read latency = the same sum minus T_DHLD.
REQ-028 SHALL produce a compile-time error if any T_* parameter is less than 1 or greater than 255.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, nadv=nwe=noe=1, ad_oe=0, ad_out=0, rsp_valid=0, rsp_rdata=0, busy=0 and req_ready=0.
REQ-030 SHALL, on reset mid-transaction, abort the transaction with no rsp_valid, and SHALL set req_ready=1 on the first cycle after rst falls.

Configuration
REQ-031 SHALL, with macro FSMC_MASTER_RDSYNC_EN defined, pass ad_in through a 2-flop synchronizer and extend the read DATA phase by 2 cycles (read latency +2); writes SHALL be unchanged.
REQ-032 SHALL, without FSMC_MASTER_RDSYNC_EN, sample ad_in directly and use no extra cycles.

Structure
REQ-033 SHALL place the state enum, the default T_* constants and the address constants READ_STATE_ADDR=18'h04000 and INFO_BASE=18'h10000 in package fsmc_pkg.
REQ-034 SHALL implement phase timing in sub-module fsmc_phase_cnt, an 8-bit down-counter with load and a done flag that reloads on every state change.

Verification
REQ-035 SHALL verify: write addr 18'h04000, data 16'h0001 with defaults -> nadv low 5 cycles, nwe low 1+2+10=13 cycles, ad_out=16'h0001 during DATA+DHOLD, busy high 29 cycles.
REQ-036 SHALL verify: read addr 18'h00005 with a responder driving 16'h07D5 -> noe low 10 cycles, rsp_valid 1 cycle with rsp_rdata=16'h07D5, busy high 26 cycles.
REQ-037 SHALL verify: req_valid held continuously for 1024 reads -> one accept per 26+1 cycles, 1024 rsp_valid pulses, no strobe overlap per REQ-025.
REQ-038 SHALL verify: rst pulsed at cycle 7 of a write -> all strobes high and ad_oe=0 the next cycle, no rsp_valid, new request accepted afterwards.
REQ-039 SHALL verify: all T_*=1 -> read of 18'h10003 completes in 4 cycles with correct data.
REQ-040 SHALL verify: with FSMC_MASTER_RDSYNC_EN, a read with defaults takes 28 cycles and a write stays at 29.
